// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game datapath.
//  N_CARDS   - default board size
//  IDX_W     - card index width
//  LFSR_W    - auto-pick LFSR width
//  LFSR_TAPS - Galois feedback taps (x^8 + x^6 + x^5 + x^4 + 1)
package memgame_pkg;

    localparam int unsigned N_CARDS = 16;
    localparam int unsigned IDX_W = $clog2(N_CARDS);
    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {S_IDLE, S_SCAN} pick_state_t;
    typedef logic [IDX_W-1:0] card_idx_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/pick_lfsr.sv
// Free-running 8-bit Galois LFSR used to randomise the auto-pick start index.
// Ports:
//  clk   in   clock
//  rst_n in   asynchronous active-low reset (loads SEED)
//  q     out  current LFSR state
module pick_lfsr
    import memgame_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/auto_pick_scanner.sv
// Auto-pick scanner: on request, walks the board round-robin from a start index and returns
// the first card that is neither matched nor the card already face-up.
// Build option: define AUTO_PICK_RANDOM_EN to start each scan at the low bits of a free-running
// LFSR; otherwise every scan starts at index 0. Port list is the same in both builds.
// Ports:
//  clk, rst_n      clock, asynchronous active-low reset
//  req_i           start a scan (sampled only while idle)
//  abort_i         cancel a scan; beats req_i
//  matched_mask_i  1 = card already matched
//  exclude_en_i    exclude_idx_i is valid
//  exclude_idx_i   card already face-up
//  avail_o         combinational: some card is eligible
//  busy_o          scan in progress
//  valid_o         1-cycle pulse, pick_idx_o is fresh
//  none_o          1-cycle pulse, full scan found nothing
//  pick_idx_o      last pick, held until the next valid_o
module auto_pick_scanner #(
    parameter int unsigned                        N_CARDS   = memgame_pkg::N_CARDS,
    parameter int unsigned                        IDX_W     = $clog2(N_CARDS),
    parameter logic [memgame_pkg::LFSR_W-1:0]     LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_i,
    input  logic               abort_i,
    input  logic [N_CARDS-1:0] matched_mask_i,
    input  logic               exclude_en_i,
    input  logic [IDX_W-1:0]   exclude_idx_i,
    output logic               avail_o,
    output logic               busy_o,
    output logic               valid_o,
    output logic               none_o,
    output logic [IDX_W-1:0]   pick_idx_o
);
    import memgame_pkg::*;

    typedef logic [IDX_W-1:0] idx_t;

    pick_state_t        state_q, state_d;
    idx_t               idx_q, idx_d;
    idx_t               cnt_q, cnt_d;
    idx_t               pick_q, pick_d;
    logic               valid_q, valid_d;
    logic               none_q, none_d;
    logic [N_CARDS-1:0] elig;
    idx_t               start_idx;

`ifdef AUTO_PICK_RANDOM_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              unused_lfsr_bits;

    pick_lfsr #(
        .SEED (LFSR_SEED)
    ) u_pick_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign start_idx        = lfsr_q[IDX_W-1:0];
    assign unused_lfsr_bits = ^lfsr_q;
`else
    localparam logic [LFSR_W-1:0] seed_unused = LFSR_SEED;

    assign start_idx = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pick_q  <= '0;
            valid_q <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pick_q  <= pick_d;
            valid_q <= valid_d;
            none_q  <= none_d;
        end
    end

    // Eligibility, availability and next state
    always_comb begin
        for (int unsigned i = 0; i < N_CARDS; i++) begin
            elig[i] = !matched_mask_i[i] && !(exclude_en_i && (idx_t'(i) == exclude_idx_i));
        end
        avail_o = |elig;

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pick_d  = pick_q;
        valid_d = 1'b0;
        none_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i && !abort_i) begin
                    state_d = S_SCAN;
                    idx_d   = start_idx;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (elig[idx_q]) begin
                    pick_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // N_CARDS is a power of two, so the index wraps by overflow.
                    idx_d = idx_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == idx_t'(N_CARDS - 1)) begin
                        none_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        valid_o    = valid_q;
        none_o     = none_q;
        pick_idx_o = pick_q;
    end

endmodule

// File: tb/tb_auto_pick_scanner.sv
module tb_auto_pick_scanner;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         abort = 1'b0;
    logic         ex_en = 1'b0;
    logic [N-1:0] mask = '0;
    logic [3:0]   ex_idx = '0;
    logic         avail, busy, valid, none;
    logic [3:0]   pick;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_pick = 0;
    logic [7:0] m_lfsr;

    typedef struct {
        bit is_none;
        int idx;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    auto_pick_scanner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .abort_i        (abort),
        .matched_mask_i (mask),
        .exclude_en_i   (ex_en),
        .exclude_idx_i  (ex_idx),
        .avail_o        (avail),
        .busy_o         (busy),
        .valid_o        (valid),
        .none_o         (none),
        .pick_idx_o     (pick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR sequence: seed A5, Galois polynomial with taps B8, one step per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    task automatic chk(input string name, input int act, input int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req_v, cyc);
        end
    endtask

    function automatic int start_of_scan();
`ifdef AUTO_PICK_RANDOM_EN
        return int'(m_lfsr[3:0]);
`else
        return 0;
`endif
    endfunction

    // First eligible card walking round-robin from s; c0 is cyc when req is driven.
    function automatic exp_t model(input logic [N-1:0] m, input bit en, input int ex,
                                   input int s, input int c0);
        exp_t e;
        e.is_none = 1'b1;
        e.idx = 0;
        e.cyc = c0 + N + 1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (s + k) % N;
            if (!m[j] && !(en && j == ex)) begin
                e.is_none = 1'b0;
                e.idx = j;
                e.cyc = c0 + 2 + k;
                return e;
            end
        end
        return e;
    endfunction

    // Monitor: samples just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (valid || none) begin
                chk("excl", int'(valid && none), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected: valid=%0d none=%0d pick=%0d expected no output",
                             valid, none, pick);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_none", int'(none), int'(e.is_none));
                    chk("when", cyc, e.cyc);
                    if (e.is_none) begin
                        chk("avail_at_none", int'(avail), 0);
                    end else begin
                        chk("pick", int'(pick), e.idx);
                        last_pick = e.idx;
                    end
                end
            end
            chk("pick_hold", int'(pick), last_pick);
        end
    end

    // Called at a falling edge; leaves the bench one falling edge later with req dropped.
    task automatic issue(input logic [N-1:0] m, input bit en, input int ex, input bit push,
                         output int c0, output exp_t e);
        mask = m;
        ex_en = en;
        ex_idx = 4'(ex);
        req = 1'b1;
        c0 = cyc;
        e = model(m, en, ex, start_of_scan(), c0);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2 * N + 4) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_zero_mask(input string name);
        int   c0;
        exp_t e;
        issue('0, 1'b0, 0, 1'b1, c0, e);
        chk({name, "_busy_t1"}, int'(busy), 1);
        @(negedge clk);
        chk({name, "_busy_t2"}, int'(busy), 0);
        wait_done(name);
`ifndef AUTO_PICK_RANDOM_EN
        chk({name, "_pick0"}, int'(pick), 0);
`endif
    endtask

    initial begin
        int   c0;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_none", int'(none), 0);
        chk("rst_pick", int'(pick), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: empty mask
        test_zero_mask("t1");

        // 2: lower half matched, card 8 face-up
        issue(16'h00FF, 1'b1, 8, 1'b1, c0, e);
        repeat (10) begin
            chk("t2_avail", int'(avail), 1);
            @(negedge clk);
        end
        wait_done("t2");
`ifndef AUTO_PICK_RANDOM_EN
        chk("t2_pick9", int'(pick), 9);
`endif

        // 3: everything matched
        @(negedge clk);
        mask = 16'hFFFF;
        ex_en = 1'b0;
        @(negedge clk);
        chk("t3_avail", int'(avail), 0);
        issue(16'hFFFF, 1'b0, 0, 1'b1, c0, e);
        wait_done("t3");

        // 4: abort mid-scan; only a hit in the first two scanned cards can still report
        @(negedge clk);
        issue(16'h7FFF, 1'b0, 0, 1'b0, c0, e);
        if (!e.is_none && e.cyc <= c0 + 3) exp_q.push_back(e);
        @(negedge clk);
`ifndef AUTO_PICK_RANDOM_EN
        req = 1'b1;
`endif
        @(negedge clk);
        req = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy_after_abort", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk("t4_busy_end", int'(busy), 0);
        chk("t4_pending", exp_q.size(), 0);
        exp_q.delete();

        // 6: async reset mid-scan
        issue(16'h3FFF, 1'b0, 0, 1'b1, c0, e);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(valid), 0);
        chk("t6_none", int'(none), 0);
        chk("t6_pick", int'(pick), 0);
        exp_q.delete();
        last_pick = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_zero_mask("t6_after");

        // 5: randomised requests against the reference model
        for (int it = 0; it < 1000; it++) begin
            logic [N-1:0] m;
            int           sel;
            sel = $urandom_range(0, 7);
            m = N'($urandom);
            if (sel == 0) begin
                m = '1;
            end else if (sel == 1) begin
                m = '1;
                m[$urandom_range(0, N - 1)] = 1'b0;
            end else if (sel == 2) begin
                m = '0;
            end
            issue(m, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 1'b1, c0, e);
            wait_done("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
